debug_trace_fifo: RTL
=====================

Name: debug_trace_fifo

Overview:
- Buffers 32-bit debug/trace words produced by the RV32IM pipeline and hands them one at a time to the debug SoC's 32-bit input PIO, which the host polls over Avalon.
- The host acknowledges each word it reads by toggling one bit of an output PIO.
- Sits directly upstream of the input PIO and drives its in_port.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; count width is AW+1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  producer has a word this cycle.
- wr_data  input  32  trace word.
- wr_ready  output  1  FIFO not full; a word is accepted on wr_valid && wr_ready.
- clr  input  1  synchronous flush pulse.
- ack_toggle  input  1  host acknowledge, driven from an output PIO bit; each level change pops one word.
- out_data  output  32  head word; drives the input PIO's in_port.
- out_valid  output  1  FIFO non-empty.
- count  output  AW+1  current occupancy.
- overflow  output  1  sticky: a word was offered while full.

Behaviour:
- Reset (async, reset_n=0):
  - Pointers, count and overflow are 0; ack_q is 0; storage contents are don't-care.
  - Outputs: out_valid=0, out_data=0 (masked while empty), wr_ready=1.
- Storage is a flop array.
  - out_data = mem[rd_ptr] when count!=0, else 32'h0.
  - out_valid = (count!=0).
- Push: wr_valid && count<DEPTH.
  - mem[wr_ptr]<=wr_data; wr_ptr increments modulo DEPTH (natural wrap).
  - Latency: a word written at edge N is visible on out_data/out_valid after edge N, provided the FIFO was empty.
- Acknowledge detection:
  - ack_q<=ack_toggle every cycle.
  - pop_req = ack_toggle ^ ack_q, a one-cycle pulse per host toggle.
- Pop: pop_req && count!=0; rd_ptr increments modulo DEPTH.
- pop_req while empty: ignored; no state change other than ack_q.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - When count==DEPTH, a pop frees no slot for that same cycle's push: wr_ready is based on registered count only.
- Full:
  - wr_ready=0.
  - wr_valid while full drops the word and sets overflow=1; it stays set until clr or reset.
- clr (synchronous, highest priority over push/pop):
  - Pointers, count and overflow go to 0.
  - ack_q still tracks ack_toggle, so a pending toggle is consumed, not replayed.
- Host protocol: read out_data/out_valid through the PIO (one extra cycle of PIO read latency), then invert the ack bit. At most one pop per toggle edge.
- Reset mid-transfer: all buffered words are lost. The host must also reset its ack bit to 0, since both sides reset to 0 and stay consistent.

Optional Feature:
- Macro: DEBUG_TRACE_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_count[15:0].
  - Increments once per dropped word and saturates at 16'hFFFF.
  - Cleared by clr and reset.
- Undefined:
  - Port and counter are absent; only the sticky overflow bit remains.

Decomposition:
- Shared package debug_trace_pkg:
  - TRACE_W=32 and DEFAULT_DEPTH=16.
  - Typedef trace_word_t (logic [31:0]).
  - Drop-counter width constant DROP_CNT_W=16.
- Sub-module: debug_trace_fifo_mem, the flop array with write port and async read. Pointer/count/ack/overflow control stays in the top.

Test Plan:
- Reset, then push 32'hDEAD_BEEF → next cycle out_valid=1, out_data=32'hDEADBEEF, count=1; toggle ack 0→1 → after one edge count=0, out_valid=0, out_data=0.
- Push 16 words 0..15 with no ack → count=16, wr_ready=0. Push 32'h55 → overflow=1 and the word is dropped. Then toggle ack 16 times → reads are 0..15 in order; overflow stays 1 until a clr pulse.
- Hold wr_valid=1 with count=5 and toggle ack in the same cycle → count stays 5; head advances one entry.
- Wrap-around: push 12, pop 10, push 12 → count=14, order preserved across the pointer wrap.
- Toggle ack while empty → no change, no underflow. Then push 32'hA5 → out_data=32'hA5, not consumed by the earlier toggle.
- Assert reset_n=0 mid-sequence with count=7 → immediately count=0, out_valid=0, wr_ready=1. With DEBUG_TRACE_FIFO_DROP_CNT_EN defined: 3 drops while full → drop_count=3.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace FIFO.
package debug_trace_pkg;
  localparam int TRACE_W       = 32;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DROP_CNT_W    = 16;

  typedef logic [TRACE_W-1:0] trace_word_t;
endpackage

// File: rtl/debug_trace_fifo_mem.sv
// Flop-array storage for the trace FIFO: one synchronous write port, one async read port.
module debug_trace_fifo_mem
  import debug_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_word_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_word_t   rdata_o
);
  // No reset: contents are only observed through the occupancy-masked head.
  trace_word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/debug_trace_fifo.sv
// Trace-word FIFO feeding a host-polled PIO; each host ack toggle pops one word.
// Optional drop counter enabled by defining DEBUG_TRACE_FIFO_DROP_CNT_EN.
module debug_trace_fifo
  import debug_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  trace_word_t           wr_data,
  output logic                  wr_ready,
  input  logic                  clr,
  input  logic                  ack_toggle,
  output trace_word_t           out_data,
  output logic                  out_valid,
  output logic [AW:0]           count,
`ifdef DEBUG_TRACE_FIFO_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_count,
`endif
  output logic                  overflow
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ack_q, overflow_q;
  logic          full, empty, pop_req, push, pop, drop;
  trace_word_t   rd_data;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop_req = ack_toggle ^ ack_q;
  // Fullness uses the registered count only, so a same-cycle pop never admits a push.
  assign push    = wr_valid && !full;
  assign pop     = pop_req && !empty;
  assign drop    = wr_valid && full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ack_q <= ack_toggle;
      if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (AW+1)'(1);
          2'b01:   count_q <= count_q - (AW+1)'(1);
          default: count_q <= count_q;
        endcase
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

`ifdef DEBUG_TRACE_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        drop_cnt_q <= '0;
    else if (clr)                        drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
  end

  assign drop_count = drop_cnt_q;
`endif

  debug_trace_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push && !clr),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : rd_data;
  assign wr_ready  = !full;
  assign count     = count_q;
  assign overflow  = overflow_q;
endmodule
